// File: rtl/dcache_wb_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_wb_if
// Purpose  : CPU load/store port and serial memory bus bundle for dcache_wb.
// Revision : 1.0
// ============================================================================
interface dcache_wb_if #(
   parameter int RV          = 16,
   parameter int PA          = 22,
   parameter int LINE_LENGTH = 4,
   parameter int BUS_W       = 4
);
   localparam int MA_W = PA - $clog2(LINE_LENGTH);

   logic             req;
   logic [PA-1:0]    paddr;
   logic             write;
   logic             is_byte;
   logic [RV-1:0]    wdata;
   logic             ready;
   logic [RV-1:0]    rdata;

   logic             mem_req;
   logic             mem_write;
   logic [MA_W-1:0]  mem_addr;
   logic [BUS_W-1:0] mem_wdata;
   logic [BUS_W-1:0] mem_rdata;
   logic             mem_strobe;

   modport slave (
      input  req, paddr, write, is_byte, wdata, mem_rdata, mem_strobe,
      output ready, rdata, mem_req, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output req, paddr, write, is_byte, wdata, mem_rdata, mem_strobe,
      input  ready, rdata, mem_req, mem_write, mem_addr, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/dcache_wb.sv
`default_nettype none
// ============================================================================
// Module   : dcache_wb
// Purpose  : Direct-mapped write-back/write-allocate data cache with a narrow
//            serial line-fill bus. Optional flush engine: CACHE_FLUSH_EN.
// Revision : 1.0
// ============================================================================
module dcache_wb #(
   parameter int RV          = 16,
   parameter int PA          = 22,
   parameter int LINE_LENGTH = 4,
   parameter int NLINES      = 4,
   parameter int BUS_W       = 4
) (
   input  logic       clk,
   input  logic       reset,
`ifdef CACHE_FLUSH_EN
   input  logic       flush,
   output logic       flush_busy,
`endif
   dcache_wb_if.slave bus
);
   localparam int OFF_W  = $clog2(LINE_LENGTH);
   localparam int IDX_W  = $clog2(NLINES);
   localparam int TAG_W  = PA - OFF_W - IDX_W;
   localparam int LINE_W = LINE_LENGTH * 8;
   localparam int BEATS  = LINE_W / BUS_W;
   localparam int BEAT_W = $clog2(BEATS);
   localparam int BSEL_W = $clog2(LINE_W);
   localparam int BUS_SH = $clog2(BUS_W);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WB    = 3'd1,
      S_FILL  = 3'd2,
      S_DONE  = 3'd3
`ifdef CACHE_FLUSH_EN
      , S_FLUSH = 3'd4
`endif
   } state_t;

   logic [LINE_W-1:0] data_q [NLINES];
   logic [TAG_W-1:0]  tag_q  [NLINES];
   logic [NLINES-1:0] valid_q, valid_d;
   logic [NLINES-1:0] dirty_q, dirty_d;
   state_t            state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;

   logic [OFF_W-1:0]  off, off_w;
   logic [IDX_W-1:0]  idx, vidx;
   logic [TAG_W-1:0]  tag;
   logic [BSEL_W-1:0] bb_off, bw_off, beat_bit;
   logic              hit;
   logic [LINE_W-1:0] line_wr;
   logic              store_we, fill_we, tag_we;
   logic              mem_req, mem_write;
   logic [PA-OFF_W-1:0] mem_addr;
   logic              ready;

`ifdef CACHE_FLUSH_EN
   logic              flushing_q, flushing_d;
   logic [IDX_W-1:0]  scan_q, scan_d;
   logic              scan_next;
`endif

   assign off    = bus.paddr[OFF_W-1:0];
   assign idx    = bus.paddr[OFF_W +: IDX_W];
   assign tag    = bus.paddr[PA-1 -: TAG_W];
   // RV-wide accesses drop the sub-word address bits
   assign off_w  = off & ~OFF_W'(RV/8 - 1);
   assign bb_off = {off, 3'b000};
   assign bw_off = {off_w, 3'b000};
   assign beat_bit = {beat_q, {BUS_SH{1'b0}}};
   assign hit    = valid_q[idx] && (tag_q[idx] == tag);

`ifdef CACHE_FLUSH_EN
   assign vidx       = flushing_q ? scan_q : idx;
   assign flush_busy = flushing_q;
`else
   assign vidx       = idx;
`endif

   always_comb begin
      ready = !reset && bus.req && (state_q == S_IDLE) && hit;
`ifdef CACHE_FLUSH_EN
      ready = ready && !flush;
`endif
   end

   assign bus.ready     = ready;
   assign bus.rdata     = bus.is_byte ? {{(RV-8){1'b0}}, data_q[idx][bb_off +: 8]}
                                      : data_q[idx][bw_off +: RV];
   assign bus.mem_req   = mem_req;
   assign bus.mem_write = mem_write;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = data_q[vidx][beat_bit +: BUS_W];

   always_comb begin
      line_wr = data_q[idx];
      if (bus.is_byte) line_wr[bb_off +: 8]  = bus.wdata[7:0];
      else             line_wr[bw_off +: RV] = bus.wdata;
   end

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      valid_d   = valid_q;
      dirty_d   = dirty_q;
      store_we  = 1'b0;
      fill_we   = 1'b0;
      tag_we    = 1'b0;
      mem_req   = 1'b0;
      mem_write = 1'b0;
      mem_addr  = {tag, idx};
`ifdef CACHE_FLUSH_EN
      flushing_d = flushing_q;
      scan_d     = scan_q;
      scan_next  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
`ifdef CACHE_FLUSH_EN
            if (flush) begin
               state_d    = S_FLUSH;
               flushing_d = 1'b1;
               scan_d     = '0;
            end else
`endif
            if (bus.req) begin
               if (hit) begin
                  if (bus.write) begin
                     store_we     = 1'b1;
                     dirty_d[idx] = 1'b1;
                  end
               end else if (valid_q[idx] && dirty_q[idx]) begin
                  state_d = S_WB;
               end else begin
                  state_d      = S_FILL;
                  valid_d[idx] = 1'b0;
               end
            end
         end
         S_WB: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            mem_addr  = {tag_q[vidx], vidx};
            if (bus.mem_strobe) begin
               if (beat_q == BEAT_W'(BEATS - 1)) begin
                  beat_d = '0;
`ifdef CACHE_FLUSH_EN
                  if (flushing_q) begin
                     dirty_d[scan_q] = 1'b0;
                     scan_next       = 1'b1;
                  end else
`endif
                  begin
                     state_d      = S_FILL;
                     valid_d[idx] = 1'b0;
                  end
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         S_FILL: begin
            mem_req = 1'b1;
            if (bus.mem_strobe) begin
               fill_we = 1'b1;
               if (beat_q == BEAT_W'(BEATS - 1)) begin
                  beat_d       = '0;
                  tag_we       = 1'b1;
                  valid_d[idx] = 1'b1;
                  dirty_d[idx] = 1'b0;
                  state_d      = S_DONE;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
`ifdef CACHE_FLUSH_EN
         S_FLUSH: begin
            if (valid_q[scan_q] && dirty_q[scan_q]) state_d = S_WB;
            else                                    scan_next = 1'b1;
         end
`endif
         default: state_d = S_IDLE;
      endcase
`ifdef CACHE_FLUSH_EN
      // Line visited: move to the next one or leave the scan
      if (scan_next) begin
         if (scan_q == IDX_W'(NLINES - 1)) begin
            state_d    = S_IDLE;
            flushing_d = 1'b0;
         end else begin
            scan_d  = scan_q + 1'b1;
            state_d = S_FLUSH;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         valid_q <= '0;
         dirty_q <= '0;
`ifdef CACHE_FLUSH_EN
         flushing_q <= 1'b0;
         scan_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
`ifdef CACHE_FLUSH_EN
         flushing_q <= flushing_d;
         scan_q     <= scan_d;
`endif
      end
   end

   // Line data and tags carry no reset; validity is tracked by valid_q
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (store_we) data_q[idx] <= line_wr;
         if (fill_we)  data_q[idx][beat_bit +: BUS_W] <= bus.mem_rdata;
         if (tag_we)   tag_q[idx] <= tag;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_dcache_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_wb
// Purpose  : Random and directed accesses against a flat-memory reference model.
// Revision : 1.0
// ============================================================================
module tb_dcache_wb;
   localparam int RV = 16, PA = 22, LL = 4, NL = 4, BW = 4, BEATS = 8;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } xfer_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   gap_en   = 1'b0;
   bit   stray_en = 1'b0;

   logic [31:0] back    [int];
   logic [7:0]  cpu_mem [int];
   bit          m_valid [NL];
   bit          m_dirty [NL];
   int          m_tag   [NL];
   xfer_t       wb_q[$];
   int          fill_q[$];

   int          rsp_beat = 0;
   bit          rsp_took = 1'b0;
   bit          rsp_wr   = 1'b0;
   int          rsp_addr = 0;
   logic [31:0] rsp_line = '0;

   dcache_wb_if #(.RV(RV), .PA(PA), .LINE_LENGTH(LL), .BUS_W(BW)) bus ();

`ifdef CACHE_FLUSH_EN
   logic flush, flush_busy;
`endif

   dcache_wb #(.RV(RV), .PA(PA), .LINE_LENGTH(LL), .NLINES(NL), .BUS_W(BW)) dut (
      .clk        (clk),
      .reset      (reset),
`ifdef CACHE_FLUSH_EN
      .flush      (flush),
      .flush_busy (flush_busy),
`endif
      .bus        (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] init_line(int la);
      if (la == 4) return 32'h87654321;
      return 32'(la * 32'h9E3779B1 + 32'h01234567);
   endfunction

   function automatic logic [31:0] mem_line(int la);
      return back.exists(la) ? back[la] : init_line(la);
   endfunction

   // Value the CPU should see at byte address a
   function automatic logic [7:0] exp_byte(int a);
      if (cpu_mem.exists(a)) return cpu_mem[a];
      return 8'(mem_line(a >> 2) >> ((a & 3) * 8));
   endfunction

   function automatic logic [31:0] exp_line(int la);
      return {exp_byte(la*4+3), exp_byte(la*4+2), exp_byte(la*4+1), exp_byte(la*4)};
   endfunction

   // Memory side: serves fills from back[], collects writebacks
   always @(negedge clk) begin
      if (reset) begin
         rsp_beat       = 0;
         rsp_took       = 1'b0;
         bus.mem_strobe = 1'b0;
         bus.mem_rdata  = '0;
      end else begin
         if (rsp_took) begin
            rsp_beat++;
            if (rsp_beat == BEATS) begin
               if (rsp_wr) begin
                  back[rsp_addr] = rsp_line;
                  wb_q.push_back('{rsp_addr, rsp_line});
               end else begin
                  fill_q.push_back(rsp_addr);
               end
               rsp_beat = 0;
            end
         end
         rsp_took       = 1'b0;
         bus.mem_strobe = 1'b0;
         if (bus.mem_req) begin
            if (rsp_beat == 0) begin
               rsp_addr = int'(bus.mem_addr);
               rsp_wr   = bus.mem_write;
               rsp_line = mem_line(rsp_addr);
            end else begin
               check("mem_addr_stable", 64'(bus.mem_addr), 64'(rsp_addr));
               check("mem_write_stable", 64'(bus.mem_write), 64'(rsp_wr));
            end
            if (!gap_en || $urandom_range(0, 2) != 0) begin
               bus.mem_strobe = 1'b1;
               rsp_took       = 1'b1;
               if (rsp_wr)
                  rsp_line = (rsp_line & ~(32'hF << (rsp_beat * 4))) |
                             (32'(bus.mem_wdata) << (rsp_beat * 4));
               else
                  bus.mem_rdata = 4'(rsp_line >> (rsp_beat * 4));
            end
         end else if (stray_en) begin
            bus.mem_strobe = 1'($urandom_range(0, 1));
            bus.mem_rdata  = 4'($urandom);
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < NL; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      cpu_mem.delete();
   endtask

   task automatic access(input int a_raw, input bit wr, input bit isb, input logic [15:0] wd);
      int          a, la, idx, tg, n, vla;
      bit          hit, dirty_v;
      logic [15:0] exp_rd;
      logic [31:0] vline;
      a       = isb ? a_raw : (a_raw & ~1);
      la      = a >> 2;
      idx     = la & 3;
      tg      = a >> 4;
      hit     = m_valid[idx] && (m_tag[idx] == tg);
      dirty_v = !hit && m_valid[idx] && m_dirty[idx];
      vla     = m_tag[idx] * 4 + idx;
      vline   = exp_line(vla);
      exp_rd  = isb ? {8'h00, exp_byte(a)} : {exp_byte(a + 1), exp_byte(a)};
      wb_q.delete();
      fill_q.delete();
      bus.req     = 1'b1;
      bus.paddr   = PA'(a_raw);
      bus.write   = wr;
      bus.is_byte = isb;
      bus.wdata   = wd;
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.ready) break;
         n++;
         if (n > 400) begin
            check("ready_timeout", 64'(bus.ready), 64'd1);
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!wr) check("rdata", 64'(bus.rdata), 64'(exp_rd));
      if (!gap_en) check("latency", 64'(n), 64'(hit ? 0 : (dirty_v ? 2*BEATS+2 : BEATS+2)));
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      check("wb_count", 64'(wb_q.size()), 64'(dirty_v));
      if (dirty_v && wb_q.size() > 0) begin
         check("wb_addr", 64'(wb_q[0].addr), 64'(vla));
         check("wb_data", 64'(wb_q[0].data), 64'(vline));
      end
      check("fill_count", 64'(fill_q.size()), 64'(!hit));
      if (!hit && fill_q.size() > 0) check("fill_addr", 64'(fill_q[0]), 64'(la));
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      if (!hit) m_dirty[idx] = 1'b0;
      if (wr) begin
         m_dirty[idx] = 1'b1;
         cpu_mem[a]   = wd[7:0];
         if (!isb) cpu_mem[a + 1] = wd[15:8];
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a, t, n;
      reset       = 1'b1;
      bus.req     = 1'b0;
      bus.paddr   = '0;
      bus.write   = 1'b0;
      bus.is_byte = 1'b0;
      bus.wdata   = '0;
`ifdef CACHE_FLUSH_EN
      flush = 1'b0;
`endif
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      bus.req   = 1'b1;
      bus.paddr = 22'h000010;
      @(negedge clk);
      check("reset_ready", 64'(bus.ready), 64'd0);
      check("reset_mem_req", 64'(bus.mem_req), 64'd0);
      check("reset_mem_write", 64'(bus.mem_write), 64'd0);
`ifdef CACHE_FLUSH_EN
      check("reset_flush_busy", 64'(flush_busy), 64'd0);
`endif
      @(posedge clk);
      #1;
      reset   = 1'b0;
      bus.req = 1'b0;
      @(posedge clk);
      #1;

      // Cold miss, byte store hit, then dirty eviction
      access(32'h10, 1'b0, 1'b0, 16'h0);
      access(32'h11, 1'b1, 1'b1, 16'h005A);
      access(32'h10, 1'b0, 1'b0, 16'h0);
      access(32'h50, 1'b0, 1'b0, 16'h0);

      // Reset three beats into a fill
      bus.req     = 1'b1;
      bus.paddr   = 22'h000014;
      bus.write   = 1'b0;
      bus.is_byte = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("abort_mem_req", 64'(bus.mem_req), 64'd0);
      check("abort_ready", 64'(bus.ready), 64'd0);
      @(posedge clk);
      #1;
      reset   = 1'b0;
      bus.req = 1'b0;
      model_reset();
      access(32'h14, 1'b0, 1'b0, 16'h0);

      // Stray strobes while idle must not disturb anything
      stray_en = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      access(32'h15, 1'b0, 1'b1, 16'h0);

`ifdef CACHE_FLUSH_EN
      access(32'h16, 1'b1, 1'b0, 16'hBEEF);
      access(32'h1C, 1'b1, 1'b0, 16'hC0DE);
      access(32'h00, 1'b0, 1'b0, 16'h0);
      wb_q.delete();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_busy_rise", 64'(flush_busy), 64'd1);
      n = 0;
      while (flush_busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("flush_busy_fall", 64'(flush_busy), 64'd0);
      @(posedge clk);
      #1;
      check("flush_wb_count", 64'(wb_q.size()), 64'd2);
      if (wb_q.size() == 2) begin
         check("flush_wb0_addr", 64'(wb_q[0].addr), 64'd5);
         check("flush_wb0_data", 64'(wb_q[0].data), 64'(exp_line(5)));
         check("flush_wb1_addr", 64'(wb_q[1].addr), 64'd7);
         check("flush_wb1_data", 64'(wb_q[1].data), 64'(exp_line(7)));
      end
      for (int i = 0; i < NL; i++) m_dirty[i] = 1'b0;
      access(32'h16, 1'b0, 1'b0, 16'h0);
      access(32'h1C, 1'b0, 1'b0, 16'h0);
`endif

      // Random traffic over a few tags, including the top of the address space
      for (int k = 0; k < 250; k++) begin
         gap_en = 1'($urandom_range(0, 1));
         t = $urandom_range(0, 3);
         a = ((t == 3 ? 32'h3FFFF : t) << 4) | $urandom_range(0, 15);
         access(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
